// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM for the RV32I core: sequences one shared ALU and one
// unified memory port through fetch/decode/execute/memory/writeback for each instruction.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [7:0] TmoLast  = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAddr,
    StMemRd, StMemWb, StMemWr, StBranch, StJal, StTrap
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              live_q;
  logic              in_mem;
  logic              taken;

  assign in_mem  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign taken   = funct3[0] ? !zero : zero;
  assign retired = retired_q;

  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    retired_d  = retired_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    result_src = 2'd0;
    instr_done = 1'b0;
    trap       = 1'b0;
    // live_q stays low while reset is held so every output reads 0 and the FSM is frozen.
    if (live_q) begin
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd2;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            result_src = 2'd2;
            state_d    = StDecode;
          end
        end
        StDecode: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          if (opcode == OpR) state_d = StExecR;
          else if (opcode == OpI) state_d = StExecI;
          else if (opcode == OpLoad || opcode == OpStore) state_d = StMemAddr;
          else if (opcode == OpBranch) state_d = StBranch;
          else if (opcode == OpJal) state_d = StJal;
          else state_d = StTrap;
        end
        StExecR: begin
          alu_src_a = 2'd2;
          alu_op    = 2'd2;
          state_d   = StAluWb;
        end
        StExecI: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          alu_op    = 2'd2;
          state_d   = StAluWb;
        end
        StAluWb: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemAddr: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          state_d   = (opcode == OpStore) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          mem_req = 1'b1;
          if (mem_ready) state_d = StMemWb;
        end
        StMemWb: begin
          reg_we     = 1'b1;
          result_src = 2'd1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
        StBranch: begin
          alu_src_a = 2'd2;
          alu_op    = 2'd1;
          // Only beq/bne are supported; anything else traps without touching the PC.
          if (funct3[2:1] == 2'b00) begin
            pc_we      = taken;
            pc_src     = taken;
            instr_done = 1'b1;
            state_d    = StFetch;
          end else begin
            state_d = StTrap;
          end
        end
        StJal: begin
          alu_src_a  = 2'd1;
          alu_src_b  = 2'd2;
          reg_we     = 1'b1;
          result_src = 2'd2;
          pc_we      = 1'b1;
          pc_src     = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StTrap: trap = 1'b1;
        default: state_d = StTrap;
      endcase
      // A ready on the last allowed wait cycle still completes the access.
      if (in_mem && !mem_ready) begin
        if (tmo_q == TmoLast) state_d = StTrap;
        else tmo_d = tmo_q + 8'd1;
      end
      if (instr_done) retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      tmo_q     <= '0;
      retired_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: an instruction-level phase model produces the
// expected per-cycle control vector, which is compared against the DUT every cycle.
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef struct packed {
    logic       mem_req, mem_we, ir_we, pc_we, pc_src, reg_we;
    logic [1:0] a, b, op, rs;
    logic       done, trap;
  } ctl_t;

  typedef struct {
    ctl_t c;
    bit   mr;
    bit   z;
  } cyc_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [6:0]       opcode = '0;
  logic [2:0]       funct3 = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, ir_we, pc_we, pc_src, reg_we;
  logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src;
  logic             instr_done, trap;
  logic [CNT_W-1:0] retired;

  int   vectors = 0;
  int   errors = 0;
  int   ret_model = 0;
  int   done_seen = 0;
  int   last_done_cyc = 0;
  cyc_t exp_q[$];

  mc_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .instr_done (instr_done),
    .retired    (retired),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t observed();
    return {mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src_a, alu_src_b, alu_op,
            result_src, instr_done, trap};
  endfunction

  task automatic push(input ctl_t c, input bit mr, input bit z);
    cyc_t e;
    e.c = c; e.mr = mr; e.z = z;
    exp_q.push_back(e);
  endtask

  task automatic push_trap(input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0; c.trap = 1'b1;
      push(c, rnd(), rnd());
    end
  endtask

  // Expected cycles of one instruction, phase by phase, given wait counts and the zero flag.
  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input bit zr,
                       input int fw, input int mw);
    ctl_t c;
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mem_req = 1; c.b = 2;
      push(c, 1'b0, rnd());
    end
    c = '0; c.mem_req = 1; c.b = 2; c.ir_we = 1; c.pc_we = 1; c.rs = 2;
    push(c, 1'b1, rnd());
    c = '0; c.a = 1; c.b = 1;
    push(c, rnd(), rnd());
    if (opc == OpR || opc == OpI) begin
      c = '0; c.a = 2; c.b = (opc == OpI) ? 2'd1 : 2'd0; c.op = 2;
      push(c, rnd(), rnd());
      c = '0; c.reg_we = 1; c.done = 1;
      push(c, rnd(), rnd());
    end else if (opc == OpLoad || opc == OpStore) begin
      c = '0; c.a = 2; c.b = 1;
      push(c, rnd(), rnd());
      for (int i = 0; i <= mw; i++) begin
        c = '0; c.mem_req = 1; c.mem_we = (opc == OpStore);
        c.done = (opc == OpStore) && (i == mw);
        push(c, i == mw, rnd());
      end
      if (opc == OpLoad) begin
        c = '0; c.reg_we = 1; c.rs = 1; c.done = 1;
        push(c, rnd(), rnd());
      end
    end else if (opc == OpBranch) begin
      c = '0; c.a = 2; c.op = 1;
      if (f3 == 3'b000 || f3 == 3'b001) begin
        c.done = 1;
        c.pc_we = (f3 == 3'b000) ? zr : !zr;
        c.pc_src = c.pc_we;
        push(c, rnd(), zr);
      end else begin
        push(c, rnd(), zr);
        push_trap(3);
      end
    end else if (opc == OpJal) begin
      c = '0; c.a = 1; c.b = 2; c.reg_we = 1; c.rs = 2; c.pc_we = 1; c.pc_src = 1; c.done = 1;
      push(c, rnd(), rnd());
    end else begin
      push_trap(3);
    end
  endtask

  task automatic play(input string name, input logic [6:0] opc, input logic [2:0] f3,
                      input int max_cyc);
    int   n;
    ctl_t obs;
    cyc_t e;
    n = 0;
    last_done_cyc = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      e = exp_q.pop_front();
      @(negedge clk);
      opcode = opc; funct3 = f3; mem_ready = e.mr; zero = e.z;
      #1;
      obs = observed();
      n++;
      vectors++;
      if (obs !== e.c || retired !== CNT_W'(ret_model)) begin
        errors++;
        $display("FAIL %s cycle %0d: ctl got %h need %h, retired got %0d need %0d",
                 name, n, obs, e.c, retired, CNT_W'(ret_model));
      end
      if (instr_done === 1'b1) begin
        done_seen++;
        last_done_cyc = n;
      end
      if (e.c.done) ret_model++;
    end
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    ret_model = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (observed() !== '0 || retired !== '0) begin
        errors++;
        $display("FAIL reset_hold: ctl got %h retired got %0d, need 0/0", observed(), retired);
      end
    end
    reset_dut();
  endtask

  task automatic test_add();
    build(OpR, 3'b000, 1'b0, 0, 0);
    play("add", OpR, 3'b000, 100);
    vectors++;
    if (last_done_cyc != 4) begin
      errors++;
      $display("FAIL add_latency: retired at cycle %0d, need 4", last_done_cyc);
    end
    build(OpI, 3'b000, 1'b0, 0, 0);
    play("addi", OpI, 3'b000, 100);
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      build(OpBranch, 3'(i[0]), bit'(i[1]), 0, 0);
      play("branch", OpBranch, 3'(i[0]), 100);
      vectors++;
      if (last_done_cyc != 3) begin
        errors++;
        $display("FAIL branch_latency: retired at cycle %0d, need 3", last_done_cyc);
      end
    end
  endtask

  task automatic test_load_wait();
    build(OpLoad, 3'b010, 1'b0, 3, 2);
    play("lw_wait", OpLoad, 3'b010, 100);
    vectors++;
    if (last_done_cyc != 10) begin
      errors++;
      $display("FAIL lw_wait_latency: retired at cycle %0d, need 10", last_done_cyc);
    end
    build(OpStore, 3'b010, 1'b0, 0, 0);
    play("sw", OpStore, 3'b010, 100);
    vectors++;
    if (last_done_cyc != 4) begin
      errors++;
      $display("FAIL sw_latency: retired at cycle %0d, need 4", last_done_cyc);
    end
  endtask

  task automatic test_timeout_edge();
    build(OpLoad, 3'b010, 1'b0, 14, 14);
    play("wait_14", OpLoad, 3'b010, 100);
    build(OpStore, 3'b010, 1'b0, 0, 14);
    play("wait_14_st", OpStore, 3'b010, 100);
  endtask

  task automatic test_timeout();
    ctl_t c;
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      c = '0; c.mem_req = 1; c.b = 2;
      push(c, 1'b0, rnd());
    end
    push_trap(5);
    play("fetch_timeout", OpR, 3'b000, 100);
    reset_dut();
    build(OpLoad, 3'b010, 1'b0, 0, 20);
    play("rd_timeout", OpLoad, 3'b010, 18);
    build(OpLoad, 3'b010, 1'b0, 0, 0);
    reset_dut();
  endtask

  task automatic test_illegal();
    build(7'b1111111, 3'b000, 1'b0, 0, 0);
    play("illegal_op", 7'b1111111, 3'b000, 100);
    reset_dut();
    build(OpBranch, 3'b010, 1'b1, 1, 0);
    play("bad_funct3", OpBranch, 3'b010, 100);
    reset_dut();
  endtask

  task automatic test_reset_mid_store();
    build(OpR, 3'b000, 1'b0, 0, 0);
    play("pre_store_add", OpR, 3'b000, 100);
    build(OpStore, 3'b010, 1'b0, 0, 10);
    play("store_mid", OpStore, 3'b010, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || observed() !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_mid_store: mem_req got %b ctl %h retired %0d, need 0/0/0",
               mem_req, observed(), retired);
    end
    reset_dut();
    build(OpJal, 3'b000, 1'b0, 0, 0);
    play("post_reset_jal", OpJal, 3'b000, 100);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] opc;
    logic [2:0] f3;
    ops[0] = OpR; ops[1] = OpI; ops[2] = OpLoad; ops[3] = OpStore; ops[4] = OpBranch;
    ops[5] = OpJal;
    for (int i = 0; i < 40; i++) begin
      opc = ops[$urandom_range(0, 5)];
      f3 = (opc == OpBranch) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      build(opc, f3, rnd(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      play("random", opc, f3, 100);
    end
  endtask

  task automatic test_wrap();
    int d0;
    reset_dut();
    d0 = done_seen;
    for (int i = 0; i < 17; i++) begin
      build(OpJal, 3'b000, 1'b0, 0, 0);
      play("jal_wrap", OpJal, 3'b000, 100);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (retired !== 4'd1 || done_seen - d0 != 17) begin
      errors++;
      $display("FAIL jal_wrap_count: retired got %0d pulses %0d, need 1 and 17",
               retired, done_seen - d0);
    end
    reset_dut();
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_timeout_edge();
    test_timeout();
    test_illegal();
    test_reset_mid_store();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
